alsu_result_collector: RTL

- Downstream stage of the ALSU datapath. Tracks each operation issued to the ALSU through a tag/flag delay line matched to the ALSU's fixed 2-cycle input-register + output-register latency.
- Samples the signed 6-bit ALSU result at the right cycle and pairs it with its tag and error flag.
- Buffers the entries in a small FIFO and presents them on a valid/ready stream to the scoreboard/host side.
- Keeps sticky overflow status and saturating drop/result counters.

---
 rtl/alsu_result_collector.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alsu_result_collector.sv
// Collects ALSU results: a tag/err delay line matched to the ALSU latency feeds a small
// result FIFO on a valid/ready stream, with sticky overflow and saturating counters.
module alsu_result_collector #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      issue_valid,
    input  logic [TAG_W-1:0]          issue_tag,
    input  logic                      issue_err,
    input  logic signed [5:0]         alsu_out,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [TAG_W-1:0]          m_tag,
    output logic signed [5:0]         m_data,
    output logic                      m_err,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic [CNT_W-1:0]          result_cnt,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = TAG_W + 7;
    localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Delay line: one {valid, tag, err} stage per ALSU pipeline register
    logic [LATENCY-1:0]            pipe_valid_q, pipe_valid_d;
    logic [LATENCY-1:0][TAG_W-1:0] pipe_tag_q, pipe_tag_d;
    logic [LATENCY-1:0]            pipe_err_q, pipe_err_d;

    assign pipe_valid_d[0] = clear ? 1'b0 : issue_valid;
    assign pipe_tag_d[0]   = issue_tag;
    assign pipe_err_d[0]   = issue_err;

    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_stage
            assign pipe_valid_d[gi] = clear ? 1'b0 : pipe_valid_q[gi-1];
            assign pipe_tag_d[gi]   = pipe_tag_q[gi-1];
            assign pipe_err_d[gi]   = pipe_err_q[gi-1];
        end
    endgenerate

    // FIFO storage and registered head; entry layout is {tag, err, data}
    logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic [EW-1:0]            head_q, head_d;
    logic                     m_valid_q, m_valid_d;
    logic                     overflow_q, overflow_d;
    logic [CNT_W-1:0]         drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]         result_cnt_q, result_cnt_d;

    logic capture;
    logic pop;
    logic full;
    logic push;
    logic drop;

    assign capture = pipe_valid_q[LATENCY-1];
    assign pop     = m_valid_q & m_ready;
    assign full    = (level_q == FULL_LVL);
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        head_d       = head_q;
        m_valid_d    = m_valid_q;
        overflow_d   = overflow_q;
        drop_cnt_d   = drop_cnt_q;
        result_cnt_d = result_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = {pipe_tag_q[LATENCY-1], pipe_err_q[LATENCY-1], alsu_out};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
            if (result_cnt_q != CNT_MAX) begin
                result_cnt_d = result_cnt_q + CNT_ONE;
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + CNT_ONE;
            end
        end

        // Head is re-read from the post-update image so a push into an empty FIFO
        // shows up after a single edge; when empty it keeps its last contents.
        m_valid_d = (level_d != '0);
        if (m_valid_d) begin
            head_d = mem_d[rd_ptr_d];
        end

        if (clear) begin
            mem_d        = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            head_d       = '0;
            m_valid_d    = 1'b0;
            overflow_d   = 1'b0;
            drop_cnt_d   = '0;
            result_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid_q <= '0;
            pipe_tag_q   <= '0;
            pipe_err_q   <= '0;
            mem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            head_q       <= '0;
            m_valid_q    <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            result_cnt_q <= '0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_tag_q   <= pipe_tag_d;
            pipe_err_q   <= pipe_err_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            head_q       <= head_d;
            m_valid_q    <= m_valid_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
            result_cnt_q <= result_cnt_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_tag      = head_q[EW-1 -: TAG_W];
    assign m_err      = head_q[6];
    assign m_data     = head_q[5:0];
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
    assign result_cnt = result_cnt_q;
    assign level      = level_q;

endmodule
